fetch_stage: RTL and testbench

Instruction-fetch stage of the RISC-V core: owns the PC, issues single-outstanding requests to instruction memory, and presents one fetched instruction at a time to decode. Decode feeds id_instr[31:7] straight into the immediate generator. Control changes (branch, JAL, JALR targets computed downstream from the generated immediate) return here as a redirect that flushes the fetch in flight.

---
 rtl/fetch_stage_pkg.sv | 22 ++
 rtl/fetch_stage.sv | 166 ++++++++++++++++
 tb/tb_fetch_stage.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared core definitions for the instruction-fetch stage: state encoding and PC constants.
`timescale 1ns/1ps
package fetch_stage_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_VALID,
        ST_HALT
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Instructions are word aligned; any low address bit set is an illegal target.
    function automatic logic pc_misaligned(input logic [1:0] pc_low);
        return pc_low != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps one request outstanding to instruction
// memory and hands one instruction at a time to decode; redirects flush the fetch in flight.
`timescale 1ns/1ps
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    output logic        fetch_misalign
);

    fetch_state_e state;
    fetch_state_e state_next;

    logic [31:0] pc;
    logic [31:0] req_addr;
    logic [31:0] instr_p1;
    logic [31:0] pc_p1;
    logic        misalign_q;
    logic        halt_pend;

    logic redirect_bad;
    logic redirect_ok;

    assign redirect_bad = redirect_valid && pc_misaligned(redirect_pc[1:0]);
    assign redirect_ok  = redirect_valid && !redirect_bad;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                state_next = redirect_bad ? ST_HALT : ST_FETCH;
            end
            ST_FETCH: begin
                if (redirect_bad) begin
                    state_next = ST_HALT;
                end else if (redirect_ok) begin
                    // A redirect racing the ack can reissue at once; otherwise the old request must drain.
                    state_next = imem_ack ? ST_FETCH : ST_DRAIN;
                end else if (imem_ack) begin
                    state_next = ST_VALID;
                end
            end
            ST_DRAIN: begin
                if (redirect_bad) begin
                    state_next = ST_HALT;
                end else if (imem_ack) begin
                    state_next = ST_FETCH;
                end
            end
            ST_VALID: begin
                if (redirect_bad) begin
                    state_next = ST_HALT;
                end else if (redirect_ok || id_ready) begin
                    state_next = ST_FETCH;
                end
            end
            ST_HALT: begin
                state_next = ST_HALT;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= RESET_PC;
            req_addr   <= RESET_PC;
            instr_p1   <= NOP_INSTR;
            pc_p1      <= 32'h0000_0000;
            misalign_q <= 1'b0;
            halt_pend  <= 1'b0;
        end else begin
            if (redirect_bad) begin
                misalign_q <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (redirect_ok) begin
                        pc       <= redirect_pc;
                        req_addr <= redirect_pc;
                    end else begin
                        req_addr <= pc;
                    end
                end
                ST_FETCH: begin
                    if (redirect_bad) begin
                        halt_pend <= !imem_ack;
                    end else if (redirect_ok) begin
                        pc <= redirect_pc;
                        if (imem_ack) begin
                            req_addr <= redirect_pc;
                        end
                    end else if (imem_ack) begin
                        // fetch -> decode register boundary
                        instr_p1 <= imem_rdata;
                        pc_p1    <= req_addr;
                        pc       <= req_addr + PC_STEP;
                    end
                end
                ST_DRAIN: begin
                    if (redirect_bad) begin
                        halt_pend <= !imem_ack;
                    end else begin
                        // The most recent redirect target is the one fetched after the drain.
                        if (redirect_ok) begin
                            pc <= redirect_pc;
                        end
                        if (imem_ack) begin
                            req_addr <= redirect_ok ? redirect_pc : pc;
                        end
                    end
                end
                ST_VALID: begin
                    if (redirect_ok) begin
                        pc       <= redirect_pc;
                        req_addr <= redirect_pc;
                    end else if (!redirect_bad && id_ready) begin
                        req_addr <= pc;
                    end
                end
                ST_HALT: begin
                    if (imem_ack) begin
                        halt_pend <= 1'b0;
                    end
                end
                default: begin
                    halt_pend <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req       = (state == ST_FETCH) || (state == ST_DRAIN) ||
                            ((state == ST_HALT) && halt_pend);
    assign imem_addr      = req_addr;
    assign id_valid       = (state == ST_VALID);
    assign id_instr       = instr_p1;
    assign id_pc          = pc_p1;
    assign id_pc4         = pc_p1 + PC_STEP;
    assign fetch_misalign = misalign_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed scoreboard bench for fetch_stage: expected instructions are queued by the
// stimulus and popped by a monitor on every decode handshake.
`timescale 1ns/1ps
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic        fetch_misalign;

    logic        rst_w;
    logic        w_req;
    logic [31:0] w_addr;
    logic        w_ack;
    logic [31:0] w_rdata;
    logic        w_valid;
    logic [31:0] w_instr;
    logic [31:0] w_pc;
    logic [31:0] w_pc4;
    logic        w_mis;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
        .id_pc4(id_pc4), .fetch_misalign(fetch_misalign)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst(rst_w),
        .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack), .imem_rdata(w_rdata),
        .redirect_valid(1'b0), .redirect_pc(32'h0000_0000),
        .id_valid(w_valid), .id_ready(1'b1), .id_instr(w_instr), .id_pc(w_pc),
        .id_pc4(w_pc4), .fetch_misalign(w_mis)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fails  = 0;
    int   hs_count = 0;
    int   mem_wait = 0;
    bit   mem_hold = 1'b1;
    int   wcnt     = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic exp_t mk(input logic [31:0] a);
        exp_t e;
        e.instr = mem_word(a);
        e.pc    = a;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_addr(input logic [31:0] a, input string name);
        int k;
        k = 0;
        while (!(imem_req && imem_addr == a) && k < 30) begin
            tick();
            k++;
        end
        check(name, imem_addr, a);
    endtask

    task automatic wait_valid(input string name);
        int k;
        k = 0;
        while (!id_valid && k < 30) begin
            tick();
            k++;
        end
        check(name, 32'(id_valid), 32'd1);
    endtask

    // Instruction memory for the main instance: optional wait states, can be stalled.
    initial begin
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            imem_ack = 1'b0;
            if (imem_req && !mem_hold) begin
                if (wcnt >= mem_wait) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem_word(imem_addr);
                    wcnt       = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    initial begin
        w_ack   = 1'b0;
        w_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            w_ack   = w_req;
            w_rdata = mem_word(w_addr);
        end
    end

    // Monitor: every accepted instruction must match the head of the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && id_valid && id_ready && !redirect_valid) begin
                hs_count++;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fails++;
                    $display("FAIL unexpected_instr: got pc %08h instr %08h, none expected", id_pc, id_instr);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_instr", id_instr, e.instr);
                    check("sb_pc", id_pc, e.pc);
                    check("sb_pc4", id_pc4, e.pc + 32'd4);
                end
            end
        end
    end

    initial begin
        int k;
        int got;
        rst            = 1'b1;
        rst_w          = 1'b1;
        id_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        repeat (3) tick();

        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(id_valid), 32'd0);
        check("rst_instr", id_instr, NOP_INSTR);
        check("rst_pc", id_pc, 32'h0);
        check("rst_pc4", id_pc4, 32'h4);
        check("rst_misalign", 32'(fetch_misalign), 32'd0);
        check("rst_addr", imem_addr, 32'h0);

        // Sequential fetch of 0, 4, 8 with one wait state
        mem_hold = 1'b0;
        mem_wait = 1;
        id_ready = 1'b1;
        sb.push_back(mk(32'h0));
        sb.push_back(mk(32'h4));
        sb.push_back(mk(32'h8));
        rst = 1'b0;
        check("req_after_release", 32'(imem_req), 32'd0);
        tick();
        check("first_req", 32'(imem_req), 32'd1);
        check("first_addr", imem_addr, 32'h0);
        k = 0;
        while (hs_count < 3 && k < 60) begin
            tick();
            k++;
        end
        id_ready = 1'b0;
        check("seq_handshakes", 32'(hs_count), 32'd3);

        // Decode stall: output held, no new request
        wait_valid("stall_valid");
        for (int i = 0; i < 5; i++) begin
            check("hold_instr", id_instr, mem_word(32'hC));
            check("hold_pc", id_pc, 32'hC);
            check("hold_req", 32'(imem_req), 32'd0);
            check("hold_valid", 32'(id_valid), 32'd1);
            tick();
        end

        // Redirect while the request to 0x10 is stalled in memory
        mem_hold = 1'b1;
        mem_wait = 0;
        sb.push_back(mk(32'hC));
        id_ready = 1'b1;
        tick();
        check("pend_req", 32'(imem_req), 32'd1);
        check("pend_addr", imem_addr, 32'h10);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("drain_addr", imem_addr, 32'h10);
            check("drain_req", 32'(imem_req), 32'd1);
            check("drain_valid", 32'(id_valid), 32'd0);
            tick();
        end
        sb.push_back(mk(32'h100));
        mem_hold = 1'b0;
        wait_addr(32'h100, "redir_addr");

        // Redirect coinciding with the ack of 0x104
        wait_addr(32'h104, "seq_after_redir");
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        id_ready       = 1'b0;
        tick();
        redirect_valid = 1'b0;
        check("same_req", 32'(imem_req), 32'd1);
        check("same_addr", imem_addr, 32'h40);
        sb.push_back(mk(32'h40));
        wait_valid("redir40_valid");
        mem_hold = 1'b1;
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        check("next_addr", imem_addr, 32'h44);

        // Misaligned redirect with a request outstanding
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        tick();
        redirect_valid = 1'b0;
        check("mis_flag", 32'(fetch_misalign), 32'd1);
        check("mis_valid", 32'(id_valid), 32'd0);
        check("mis_req_pending", 32'(imem_req), 32'd1);
        mem_hold = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            check("halt_req", 32'(imem_req), 32'd0);
            check("halt_valid", 32'(id_valid), 32'd0);
            check("halt_misalign", 32'(fetch_misalign), 32'd1);
            tick();
        end
        rst = 1'b1;
        #1;
        check("rerst_misalign", 32'(fetch_misalign), 32'd0);
        check("rerst_req", 32'(imem_req), 32'd0);
        check("rerst_instr", id_instr, NOP_INSTR);
        check("sb_empty", 32'(sb.size()), 32'd0);

        // PC wrap from the top of the address space
        tick();
        rst_w = 1'b0;
        got = 0;
        k   = 0;
        while (got < 2 && k < 30) begin
            if (w_valid) begin
                if (got == 0) begin
                    check("wrap_pc0", w_pc, 32'hFFFF_FFFC);
                    check("wrap_pc4", w_pc4, 32'h0);
                    check("wrap_instr0", w_instr, mem_word(32'hFFFF_FFFC));
                end else begin
                    check("wrap_pc1", w_pc, 32'h0);
                    check("wrap_instr1", w_instr, mem_word(32'h0));
                end
                got++;
            end
            tick();
            k++;
        end
        check("wrap_count", 32'(got), 32'd2);
        check("wrap_misalign", 32'(w_mis), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
